// File: rtl/bootram_arbiter.sv
// bootram_arbiter: two-requester (cpu, DMA) arbiter onto a single boot RAM port.
// Each access walks IDLE -> ISSUE -> WAIT -> ACK, so at most one access per 4 cycles.
module bootram_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int CPU_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_d,
  input  logic [3:0]            cpu_bytesel,
  output logic                  cpu_ack,
  output logic [31:0]           cpu_q,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [31:0]           dma_d,
  input  logic [3:0]            dma_bytesel,
  output logic                  dma_ack,
  output logic [31:0]           dma_q,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_d,
  output logic                  ram_we,
  output logic [3:0]            ram_bytesel,
  input  logic [31:0]           ram_q,
  output logic                  owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state;
  logic   cpu_last;
  logic   pick_dma;
  // cpu_last is separate from owner so that after reset the cpu counts as not-last
  assign pick_dma = dma_req && (!cpu_req || (CPU_PRIORITY == 0 && cpu_last));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_d       <= '0;
      ram_bytesel <= '0;
      owner       <= 1'b0;
      cpu_last    <= 1'b0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_q       <= '0;
      dma_q       <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req || dma_req) begin
          ram_we      <= pick_dma ? dma_we : cpu_we;
          ram_addr    <= pick_dma ? dma_addr : cpu_addr;
          ram_d       <= pick_dma ? dma_d : cpu_d;
          ram_bytesel <= pick_dma ? dma_bytesel : cpu_bytesel;
          owner       <= pick_dma;
          cpu_last    <= !pick_dma;
          state       <= ISSUE;
        end
        ISSUE: begin
          ram_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (owner) begin
            dma_q   <= ram_q;
            dma_ack <= 1'b1;
          end else begin
            cpu_q   <= ram_q;
            cpu_ack <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bootram_arbiter.sv
// tb_bootram_arbiter: directed bench for a round-robin and a cpu-priority arbiter instance.
module tb_bootram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, dma_req = 1'b0, p_cpu_req = 1'b0, p_dma_req = 1'b0;
  logic        cpu_we = 1'b0, dma_we = 1'b0;
  logic [13:0] cpu_addr = '0, dma_addr = '0;
  logic [31:0] cpu_d = '0, dma_d = '0;
  logic [3:0]  cpu_bs = '0, dma_bs = '0;
  logic        cpu_ack0, dma_ack0, ram_we0, own0, cpu_ack1, dma_ack1, ram_we1, own1;
  logic [31:0] cpu_q0, dma_q0, ram_d0, ram_q0, cpu_q1, dma_q1, ram_d1, ram_q1;
  logic [13:0] ram_addr0, ram_addr1;
  logic [3:0]  ram_bs0, ram_bs1;
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  bootram_arbiter #(.ADDR_WIDTH(14), .CPU_PRIORITY(0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d), .cpu_bytesel(cpu_bs),
    .cpu_ack(cpu_ack0), .cpu_q(cpu_q0),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_d(dma_d), .dma_bytesel(dma_bs),
    .dma_ack(dma_ack0), .dma_q(dma_q0),
    .ram_addr(ram_addr0), .ram_d(ram_d0), .ram_we(ram_we0), .ram_bytesel(ram_bs0), .ram_q(ram_q0),
    .owner(own0)
  );

  bootram_arbiter #(.ADDR_WIDTH(14), .CPU_PRIORITY(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(p_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d), .cpu_bytesel(cpu_bs),
    .cpu_ack(cpu_ack1), .cpu_q(cpu_q1),
    .dma_req(p_dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_d(dma_d), .dma_bytesel(dma_bs),
    .dma_ack(dma_ack1), .dma_q(dma_q1),
    .ram_addr(ram_addr1), .ram_d(ram_d1), .ram_we(ram_we1), .ram_bytesel(ram_bs1), .ram_q(ram_q1),
    .owner(own1)
  );

  // byte-enabled synchronous RAMs, one-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we0 && ram_bs0[i]) mem0[ram_addr0[3:0]][8*i +: 8] <= ram_d0[8*i +: 8];
      if (ram_we1 && ram_bs1[i]) mem1[ram_addr1[3:0]][8*i +: 8] <= ram_d1[8*i +: 8];
    end
    ram_q0 <= mem0[ram_addr0[3:0]];
    ram_q1 <= mem1[ram_addr1[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE just after an edge; returns inside the ACK cycle.
  task automatic run(input bit p, input string tag, input logic o, input logic we,
                     input logic [13:0] a, input bit chq, input logic [31:0] q);
    @(posedge clk); #1;
    chk({tag, " owner"}, {31'b0, p ? own1 : own0}, {31'b0, o});
    chk({tag, " ram_we issue"}, {31'b0, p ? ram_we1 : ram_we0}, {31'b0, we});
    chk({tag, " ram_addr"}, {18'b0, p ? ram_addr1 : ram_addr0}, {18'b0, a});
    @(posedge clk); #1;
    chk({tag, " ram_we wait"}, {31'b0, p ? ram_we1 : ram_we0}, 32'd0);
    chk({tag, " acks wait"}, {30'b0, p ? {cpu_ack1, dma_ack1} : {cpu_ack0, dma_ack0}}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " acks"}, {30'b0, p ? {cpu_ack1, dma_ack1} : {cpu_ack0, dma_ack0}}, {30'b0, !o, o});
    if (chq) chk({tag, " q"}, o ? (p ? dma_q1 : dma_q0) : (p ? cpu_q1 : cpu_q0), q);
  endtask

  task automatic step(input bit p, input string tag);
    @(posedge clk); #1;
    chk({tag, " acks idle"}, {30'b0, p ? {cpu_ack1, dma_ack1} : {cpu_ack0, dma_ack0}}, 32'd0);
  endtask

  task automatic set_cpu(input logic we, input logic [13:0] a, input logic [31:0] d, input logic [3:0] bs);
    cpu_we = we; cpu_addr = a; cpu_d = d; cpu_bs = bs;
  endtask

  task automatic set_dma(input logic we, input logic [13:0] a, input logic [31:0] d, input logic [3:0] bs);
    dma_we = we; dma_addr = a; dma_d = d; dma_bs = bs;
  endtask

  initial begin
    #12;
    chk("rst ram_we", {31'b0, ram_we0}, 32'd0);
    chk("rst acks", {30'b0, cpu_ack0, dma_ack0}, 32'd0);
    chk("rst owner", {31'b0, own0}, 32'd0);
    chk("rst ram_addr", {18'b0, ram_addr0}, 32'd0);
    chk("rst ram_d", ram_d0, 32'd0);
    chk("rst ram_bs", {28'b0, ram_bs0}, 32'd0);
    chk("rst cpu_q", cpu_q0, 32'd0);
    chk("rst dma_q", dma_q0, 32'd0);
    chk("rst u1 acks", {30'b0, cpu_ack1, dma_ack1}, 32'd0);
    // tie right after reset: first request taken at the first edge, cpu first
    @(negedge clk);
    reset_n = 1'b1;
    set_cpu(1'b1, 14'd3, 32'h3333_3333, 4'hF);
    set_dma(1'b1, 14'd4, 32'h4444_4444, 4'hF);
    cpu_req = 1'b1; dma_req = 1'b1;
    run(0, "tie1", 1'b0, 1'b1, 14'd3, 0, 32'd0); step(0, "tie1");
    run(0, "tie2", 1'b1, 1'b1, 14'd4, 0, 32'd0); step(0, "tie2");
    run(0, "tie3", 1'b0, 1'b1, 14'd3, 0, 32'd0); cpu_req = 1'b0; step(0, "tie3");
    run(0, "tie4", 1'b1, 1'b1, 14'd4, 0, 32'd0); dma_req = 1'b0; step(0, "tie4");
    // cpu write / preloads / read back
    set_cpu(1'b1, 14'd0, 32'hAABB_CCDD, 4'hF); cpu_req = 1'b1;
    run(0, "cwr0", 1'b0, 1'b1, 14'd0, 0, 32'd0); cpu_req = 1'b0; step(0, "cwr0");
    set_cpu(1'b1, 14'd1, 32'h1122_3344, 4'hF); cpu_req = 1'b1;
    run(0, "cwr1", 1'b0, 1'b1, 14'd1, 0, 32'd0); cpu_req = 1'b0; step(0, "cwr1");
    set_cpu(1'b1, 14'd2, 32'h1122_3344, 4'hF); cpu_req = 1'b1;
    run(0, "cwr2", 1'b0, 1'b1, 14'd2, 0, 32'd0); cpu_req = 1'b0; step(0, "cwr2");
    set_cpu(1'b0, 14'd0, 32'd0, 4'hF); cpu_req = 1'b1;
    run(0, "crd0", 1'b0, 1'b0, 14'd0, 1, 32'hAABB_CCDD); cpu_req = 1'b0; step(0, "crd0");
    // DMA partial writes
    set_dma(1'b1, 14'd1, 32'hAABB_CCDD, 4'b0011); dma_req = 1'b1;
    run(0, "dwr1", 1'b1, 1'b1, 14'd1, 0, 32'd0); dma_req = 1'b0; step(0, "dwr1");
    set_dma(1'b0, 14'd1, 32'd0, 4'hF); dma_req = 1'b1;
    run(0, "drd1", 1'b1, 1'b0, 14'd1, 1, 32'h1122_CCDD); dma_req = 1'b0; step(0, "drd1");
    set_dma(1'b1, 14'd2, 32'hAABB_CCDD, 4'b1100); dma_req = 1'b1;
    run(0, "dwr2", 1'b1, 1'b1, 14'd2, 0, 32'd0); dma_req = 1'b0; step(0, "dwr2");
    set_dma(1'b0, 14'd2, 32'd0, 4'hF); dma_req = 1'b1;
    run(0, "drd2", 1'b1, 1'b0, 14'd2, 1, 32'hAABB_3344); dma_req = 1'b0; step(0, "drd2");
    chk("cpu_q hold", cpu_q0, 32'hAABB_CCDD);
    // zero byte-enable write still pulses ram_we, leaves data intact
    set_cpu(1'b1, 14'd0, 32'h1234_5678, 4'b0000); cpu_req = 1'b1;
    run(0, "cwr_bs0", 1'b0, 1'b1, 14'd0, 0, 32'd0); cpu_req = 1'b0; step(0, "cwr_bs0");
    chk("dma_q hold", dma_q0, 32'hAABB_3344);
    set_cpu(1'b0, 14'd0, 32'd0, 4'hF); cpu_req = 1'b1;
    run(0, "crd_bs0", 1'b0, 1'b0, 14'd0, 1, 32'hAABB_CCDD); cpu_req = 1'b0; step(0, "crd_bs0");
    // reset during ISSUE of a write aborts it
    set_cpu(1'b1, 14'd0, 32'hDEAD_BEEF, 4'hF); cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("abort ram_we issue", {31'b0, ram_we0}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort ram_we", {31'b0, ram_we0}, 32'd0);
    chk("abort owner", {31'b0, own0}, 32'd0);
    chk("abort ram_d", ram_d0, 32'd0);
    chk("abort cpu_q", cpu_q0, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("abort ack1", {30'b0, cpu_ack0, dma_ack0}, 32'd0);
    @(posedge clk); #1;
    chk("abort ack2", {30'b0, cpu_ack0, dma_ack0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // post-reset tie: round-robin pointer back to cpu-first
    set_cpu(1'b0, 14'd0, 32'd0, 4'hF); set_dma(1'b0, 14'd1, 32'd0, 4'hF);
    cpu_req = 1'b1; dma_req = 1'b1;
    run(0, "post cpu", 1'b0, 1'b0, 14'd0, 1, 32'hAABB_CCDD); cpu_req = 1'b0; step(0, "post cpu");
    run(0, "post dma", 1'b1, 1'b0, 14'd1, 1, 32'h1122_CCDD); dma_req = 1'b0; step(0, "post dma");
    // cpu-priority instance: DMA starves while cpu keeps requesting
    set_cpu(1'b1, 14'd5, 32'h5555_5555, 4'hF); set_dma(1'b1, 14'd6, 32'h6666_6666, 4'hF);
    p_cpu_req = 1'b1; p_dma_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run(1, "pri cpu", 1'b0, 1'b1, 14'd5, 0, 32'd0);
      if (i == 19) p_cpu_req = 1'b0;
      step(1, "pri cpu");
    end
    run(1, "pri dma", 1'b1, 1'b1, 14'd6, 0, 32'd0); p_dma_req = 1'b0; step(1, "pri dma");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bootram_arbiter.md
BOOTRAM_ARBITER -- requirements
Module: bootram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word-address width of the shared boot RAM port.
REQ-002 SHALL have parameter CPU_PRIORITY, default 0; 0 = round-robin, 1 = cpu always wins ties.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 cpu_req  in  1  cpu access request, held until cpu_ack.
REQ-006 cpu_we  in  1  cpu write (1) / read (0).
REQ-007 cpu_addr  in  ADDR_WIDTH  cpu word address.
REQ-008 cpu_d  in  32  cpu write data.
REQ-009 cpu_bytesel  in  4  cpu byte enables, bit3 = bits 31:24.
REQ-010 cpu_ack  out  1  one-cycle completion strobe to cpu.
REQ-011 cpu_q  out  32  cpu read data, registered, valid while cpu_ack high.
REQ-012 dma_req  in  1  loader/DMA request, held until dma_ack.
REQ-013 dma_we  in  1  DMA write/read.
REQ-014 dma_addr  in  ADDR_WIDTH  DMA word address.
REQ-015 dma_d  in  32  DMA write data.
REQ-016 dma_bytesel  in  4  DMA byte enables.
REQ-017 dma_ack  out  1  one-cycle completion strobe to DMA.
REQ-018 dma_q  out  32  DMA read data, registered, valid while dma_ack high.
REQ-019 ram_addr  out  ADDR_WIDTH  to RAM port 1 addr.
REQ-020 ram_d  out  32  to RAM port 1 d.
REQ-021 ram_we  out  1  to RAM port 1 we.
REQ-022 ram_bytesel  out  4  to RAM port 1 bytesel.
REQ-023 ram_q  in  32  from RAM port 1 q; one-cycle synchronous read latency.
REQ-024 owner  out  1  0 = cpu, 1 = DMA; requester of current/last grant.

Function
REQ-025 SHALL implement FSM IDLE -> ISSUE -> WAIT -> ACK -> IDLE, one cycle in each non-IDLE state.
REQ-026 IDLE: at a rising edge with any req high, SHALL select winner, register its we/addr/d/bytesel onto ram_*, set owner, enter ISSUE; no req -> stay IDLE.
REQ-027 ram_we SHALL be high only in ISSUE, and only if winner's we was 1; ram_addr/ram_d/ram_bytesel hold last values outside ISSUE.
REQ-028 WAIT: ram_q valid; at end of WAIT SHALL capture ram_q into winner's q register and raise winner's ack.
REQ-029 ACK: winner's ack high exactly one cycle, other ack low; next edge -> IDLE.
REQ-030 Latency: ack high in the third cycle after the edge sampling req; one access per 4 cycles maximum.
REQ-031 Requester SHALL drop req on the edge where ack is high; req still high in IDLE is a new request.
REQ-032 Request inputs SHALL be sampled only in IDLE; changes in other states ignored.
REQ-033 Tie, CPU_PRIORITY=0: grant requester not granted last; after reset cpu counts as not-last (cpu wins first tie).
REQ-034 Tie, CPU_PRIORITY=1: cpu always wins; DMA may starve.
REQ-035 Writes SHALL ack identically; q after write = RAM read-during-write value, unchecked.
REQ-036 bytesel 0000 with we=1 SHALL run full cycle with ram_we=1; RAM contents unchanged.
REQ-037 cpu_q/dma_q SHALL hold value until that requester's next ack.

Reset
REQ-038 reset_n low SHALL immediately force IDLE, ram_we=0, cpu_ack=dma_ack=0, owner=0, round-robin pointer to cpu-first.
REQ-039 Reset values: ram_addr=0, ram_d=0, ram_bytesel=0, cpu_q=0, dma_q=0; in-flight access aborted, no ack.
REQ-040 After reset_n deasserts, first request sampled at the first rising edge.

Verification
REQ-041 cpu write 0xAABBCCDD bytesel 1111 addr 0, then cpu read addr 0 -> ram_we one cycle, cpu_ack 3 cycles after sampling, cpu_q=0xAABBCCDD.
REQ-042 addr 1 preloaded 0x11223344; DMA write 0xAABBCCDD bytesel 0011; read -> dma_q=0x1122CCDD; bytesel 1100 variant -> 0xAABB3344.
REQ-043 cpu_req and dma_req rise same edge, held for two accesses each -> order cpu, dma, cpu, dma; owner follows; acks never overlap.
REQ-044 CPU_PRIORITY=1, cpu re-requesting continuously, dma_req high -> no dma_ack for 20 accesses; cpu drops -> dma_ack next.
REQ-045 reset_n low during ISSUE of a write -> ram_we 0 within same cycle, no ack, owner=0; post-reset cpu read addr 0 completes normally.
